systolic_drain: RTL and testbench

Output-side de-skew and drain unit for the systolic array. The array's input side delays operand column j by j cycles, so PE column j produces its result for row r j cycles after column 0 does. This block re-aligns each row by delaying column j by N-1-j cycles. It counts a programmed number of rows and buffers them in a small FIFO. It then presents whole rows to the CFU result path over a valid/ready handshake.

---
 rtl/systolic_pkg.sv | 14 +
 rtl/drain_fifo.sv | 59 +++++
 rtl/systolic_drain.sv | 154 +++++++++++++++
 tb/tb_systolic_drain.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array result path.
package systolic_pkg;

   localparam int N_DEF      = 4;
   localparam int DW_DEF     = 32;
   localparam int ROWS_W_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_FLUSH
   } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// Show-ahead FIFO of aligned rows; a pop frees the head slot
// in the same cycle, so a push into a full FIFO with a pop is accepted.
module drain_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  count
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/systolic_drain.sv
// De-skews systolic array result columns into whole rows, counts a
// programmed number of rows and drains them over valid/ready.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int DW         = DW_DEF,
   parameter int ROWS_W     = ROWS_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ROWS_W-1:0] num_rows,
   input  logic [N-1:0]      in_valid,
   input  logic [N*DW-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*DW-1:0]   out_data,
   output logic [ROWS_W-1:0] out_row,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              skew_err
);

   localparam int FW = ROWS_W + N*DW;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [N-1:0]    al_v;
   logic [N*DW-1:0] al_d;

   // Column j waits N-1-j cycles so every column meets column N-1.
   for (genvar j = 0; j < N; j++) begin : g_col
      localparam int D = N - 1 - j;
      if (D == 0) begin : g_pass
         assign al_v[j]          = in_valid[j];
         assign al_d[j*DW +: DW] = in_data[j*DW +: DW];
      end else begin : g_dly
         logic [DW:0] dl [D];
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int k = 0; k < D; k++) begin
                  dl[k] <= '0;
               end
            end else begin
               dl[0] <= {in_valid[j], in_data[j*DW +: DW]};
               for (int k = 1; k < D; k++) begin
                  dl[k] <= dl[k-1];
               end
            end
         end
         assign al_v[j]          = dl[D-1][DW];
         assign al_d[j*DW +: DW] = dl[D-1][DW-1:0];
      end
   end

   drain_state_t      state_q, state_d;
   logic [ROWS_W-1:0] rows_q, rows_d;
   logic [ROWS_W-1:0] cnt_q, cnt_d;
   logic              ovf_d, skew_d, done_d;
   logic              push, pop;
   logic              row_ok, row_part;
   logic              f_full, f_empty, f_last;
   logic [CW-1:0]     f_count;
   logic [FW-1:0]     f_rdata;

   assign row_ok    = &al_v;
   assign row_part  = |al_v && !row_ok;
   assign out_valid = !f_empty;
   assign pop       = out_valid && out_ready;
   assign f_last    = (f_count == CW'(1));
   assign busy      = (state_q != S_IDLE);
   assign {out_row, out_data} = f_rdata;

   drain_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({cnt_q, al_d}),
      .pop   (pop),
      .rdata (f_rdata),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   always_comb begin
      state_d = state_q;
      rows_d  = rows_q;
      cnt_d   = cnt_q;
      ovf_d   = overflow;
      skew_d  = skew_err | row_part;
      done_d  = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_rows != '0) begin
                  rows_d  = num_rows;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  skew_d  = row_part;
                  state_d = S_COLLECT;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            if (row_ok) begin
               push  = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (f_full && !pop) begin
                  ovf_d = 1'b1;
               end
               if (cnt_d == rows_q) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            // Finish on the cycle the FIFO goes (or already is) empty.
            if (f_empty || (f_last && pop)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rows_q   <= '0;
         cnt_q    <= '0;
         overflow <= 1'b0;
         skew_err <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rows_q   <= rows_d;
         cnt_q    <= cnt_d;
         overflow <= ovf_d;
         skew_err <= skew_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed scoreboard bench for systolic_drain: skewed rows in,
// aligned rows checked against an expected-row queue at each pop.
module tb_systolic_drain;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int RW = 8;
   localparam int XW = N*DW;

   typedef struct packed {
      logic [RW-1:0] row;
      logic [XW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [RW-1:0] num_rows = '0;
   logic [N-1:0]  in_valid = '0;
   logic [XW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [XW-1:0] out_data;
   logic [RW-1:0] out_row;
   logic          busy;
   logic          done;
   logic          overflow;
   logic          skew_err;

   exp_t          q[$];
   int            cyc = 0;
   int            base = 0;
   int            n_sched = 0;
   int            errors = 0;
   int            checks = 0;
   int            t0[8];
   int            sidx[8];
   logic [N-1:0]  sdrop[8];
   logic          hold_v = 1'b0;
   logic [XW-1:0] hold_d = '0;
   logic [RW-1:0] hold_r = '0;

   systolic_drain #(
      .N          (N),
      .DW         (DW),
      .ROWS_W     (RW),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_rows  (num_rows),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .skew_err  (skew_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [XW-1:0] obs,
                      input logic [XW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                tag, cyc - base, obs, exp);
      end
   endtask

   function automatic logic [XW-1:0] mk_data(input int idx);
      logic [XW-1:0] d;
      for (int j = 0; j < N; j++) begin
         d[j*DW +: DW] = 32'(256*idx + j);
      end
      return d;
   endfunction

   task automatic drive();
      logic [N-1:0]  v;
      logic [XW-1:0] d;
      v = '0;
      d = '0;
      for (int s = 0; s < n_sched; s++) begin
         for (int j = 0; j < N; j++) begin
            if (cyc == t0[s] + j && !sdrop[s][j]) begin
               v[j]          = 1'b1;
               d[j*DW +: DW] = 32'(256*sidx[s] + j);
            end
         end
      end
      in_valid = v;
      in_data  = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      drive();
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic sched(input int t, input int idx,
                        input logic [N-1:0] drp);
      t0[n_sched]    = t;
      sidx[n_sched]  = idx;
      sdrop[n_sched] = drp;
      n_sched++;
   endtask

   task automatic expect_row(input int row, input int idx);
      exp_t e;
      e.row  = RW'(row);
      e.data = mk_data(idx);
      q.push_back(e);
   endtask

   task automatic begin_test(input int n, input logic rdy);
      tick();
      base      = cyc;
      n_sched   = 0;
      start     = 1'b1;
      num_rows  = RW'(n);
      out_ready = rdy;
      tick();
      start = 1'b0;
   endtask

   // Consumer side: compare every accepted row and check held rows.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && hold_v && out_valid) begin
         chk("hold_data", out_data, hold_d);
         chk("hold_row", XW'(out_row), XW'(hold_r));
      end
      if (rst_n && out_valid && out_ready) begin
         chk("pop_q_nonempty", XW'(q.size() != 0), XW'(1));
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("pop_row", XW'(out_row), XW'(e.row));
            chk("pop_data", out_data, e.data);
         end
      end
      hold_v = rst_n && out_valid && !out_ready;
      hold_d = out_data;
      hold_r = out_row;
   end

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", XW'(out_valid), XW'(0));
      chk("rst_busy", XW'(busy), XW'(0));
      chk("rst_done", XW'(done), XW'(0));
      chk("rst_overflow", XW'(overflow), XW'(0));
      chk("rst_skew_err", XW'(skew_err), XW'(0));
      chk("rst_out_data", out_data, XW'(0));
      chk("rst_out_row", XW'(out_row), XW'(0));
      rst_n = 1'b1;
      tick();

      // Basic drain, consumer always ready.
      begin_test(3, 1'b1);
      chk("t1_busy_rise", XW'(busy), XW'(1));
      for (int r = 0; r < 3; r++) begin
         sched(base + 10 + r, r, '0);
         expect_row(r, r);
      end
      wait_until(base + 13);
      chk("t1_not_yet", XW'(out_valid), XW'(0));
      wait_until(base + 14);
      chk("t1_valid14", XW'(out_valid), XW'(1));
      chk("t1_row0", XW'(out_row), XW'(0));
      chk("t1_data0", out_data, mk_data(0));
      wait_until(base + 16);
      chk("t1_row2", XW'(out_row), XW'(2));
      chk("t1_done16", XW'(done), XW'(0));
      wait_until(base + 17);
      chk("t1_done17", XW'(done), XW'(1));
      chk("t1_busy17", XW'(busy), XW'(0));
      wait_until(base + 18);
      chk("t1_done_pulse", XW'(done), XW'(0));
      wait_until(base + 25);

      // Backpressure until relative cycle 30.
      begin_test(3, 1'b0);
      for (int r = 0; r < 3; r++) begin
         sched(base + 10 + r, r, '0);
         expect_row(r, r);
      end
      wait_until(base + 14);
      chk("t2_valid14", XW'(out_valid), XW'(1));
      wait_until(base + 29);
      chk("t2_head_row", XW'(out_row), XW'(0));
      chk("t2_head_data", out_data, mk_data(0));
      chk("t2_busy", XW'(busy), XW'(1));
      wait_until(base + 30);
      out_ready = 1'b1;
      wait_until(base + 32);
      chk("t2_done32", XW'(done), XW'(0));
      wait_until(base + 33);
      chk("t2_done33", XW'(done), XW'(1));
      chk("t2_overflow", XW'(overflow), XW'(0));
      chk("t2_empty", XW'(out_valid), XW'(0));
      wait_until(base + 38);

      // Overflow: six rows into a four-deep FIFO.
      begin_test(6, 1'b0);
      for (int r = 0; r < 6; r++) begin
         sched(base + 10 + r, r, '0);
      end
      for (int r = 0; r < 4; r++) begin
         expect_row(r, r);
      end
      wait_until(base + 17);
      chk("t3_ovf_before", XW'(overflow), XW'(0));
      wait_until(base + 18);
      chk("t3_ovf_set", XW'(overflow), XW'(1));
      wait_until(base + 25);
      chk("t3_busy", XW'(busy), XW'(1));
      out_ready = 1'b1;
      wait_until(base + 28);
      chk("t3_done28", XW'(done), XW'(0));
      wait_until(base + 29);
      chk("t3_done29", XW'(done), XW'(1));
      chk("t3_ovf_sticky", XW'(overflow), XW'(1));
      wait_until(base + 35);

      // Full FIFO with push and pop in the same cycle.
      begin_test(5, 1'b0);
      for (int r = 0; r < 5; r++) begin
         sched(base + 10 + r, r, '0);
         expect_row(r, r);
      end
      wait_until(base + 17);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t4_ovf", XW'(overflow), XW'(0));
      chk("t4_head_row", XW'(out_row), XW'(1));
      wait_until(base + 20);
      out_ready = 1'b1;
      wait_until(base + 24);
      chk("t4_done", XW'(done), XW'(1));
      chk("t4_ovf_end", XW'(overflow), XW'(0));
      wait_until(base + 30);

      // Skewed row with column 2 missing.
      begin_test(2, 1'b1);
      sched(base + 10, 0, '0);
      sched(base + 11, 1, 4'b0100);
      sched(base + 12, 2, '0);
      expect_row(0, 0);
      expect_row(1, 2);
      wait_until(base + 14);
      chk("t5_skew_before", XW'(skew_err), XW'(0));
      wait_until(base + 15);
      chk("t5_skew_set", XW'(skew_err), XW'(1));
      wait_until(base + 16);
      chk("t5_row_idx", XW'(out_row), XW'(1));
      chk("t5_row_data", out_data, mk_data(2));
      wait_until(base + 17);
      chk("t5_done", XW'(done), XW'(1));
      wait_until(base + 22);

      // Zero-row start.
      begin_test(0, 1'b1);
      chk("t6_done", XW'(done), XW'(1));
      chk("t6_busy", XW'(busy), XW'(0));
      tick();
      chk("t6_done_pulse", XW'(done), XW'(0));

      // Reset in the middle of a drain.
      begin_test(3, 1'b0);
      for (int r = 0; r < 3; r++) begin
         sched(base + 10 + r, r, '0);
      end
      wait_until(base + 15);
      chk("t7_pre_valid", XW'(out_valid), XW'(1));
      chk("t7_pre_busy", XW'(busy), XW'(1));
      rst_n = 1'b0;
      tick();
      chk("t7_valid", XW'(out_valid), XW'(0));
      chk("t7_busy", XW'(busy), XW'(0));
      chk("t7_done", XW'(done), XW'(0));
      chk("t7_data", out_data, XW'(0));
      chk("t7_row", XW'(out_row), XW'(0));
      chk("t7_ovf", XW'(overflow), XW'(0));
      rst_n   = 1'b1;
      n_sched = 0;
      wait_until(base + 22);
      chk("t7_idle_valid", XW'(out_valid), XW'(0));
      chk("t7_idle_busy", XW'(busy), XW'(0));
      chk("t7_idle_skew", XW'(skew_err), XW'(0));

      chk("queue_drained", XW'(q.size()), XW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
